// File: rtl/ps2_kbd_event_rx.sv
// PS/2 keyboard receiver: synchronises the raw pins, deserialises 11-bit frames,
// folds E0/F0 prefixes into key events and queues them in a fall-through FIFO.
module ps2_kbd_event_rx #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_break,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clr_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_t;

  // Pin synchronisers; idle PS/2 lines are high
  logic clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  logic          fall_c;
  logic          stop_c;
  logic          frame_ok_c;
  logic          frame_bad_c;
  logic          tmo_hit_c;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] tmo_cnt;

  // shreg[0] is the start bit, [8:1] the data byte, [9] parity once the stop bit arrives
  assign fall_c      = clk_prev & ~clk_s2;
  assign stop_c      = fall_c && (bit_cnt == 4'd10);
  assign frame_ok_c  = stop_c && !shreg[0] && (^shreg[9:1]) && dat_s2;
  assign tmo_hit_c   = (bit_cnt != 4'd0) && !fall_c && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign frame_bad_c = (stop_c && !frame_ok_c) || tmo_hit_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt   <= 4'd0;
      shreg     <= 10'd0;
      tmo_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_bad_c;
      if (tmo_hit_c) begin
        bit_cnt <= 4'd0;
        tmo_cnt <= '0;
      end else if (fall_c) begin
        tmo_cnt <= '0;
        if (stop_c) begin
          bit_cnt <= 4'd0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {dat_s2, shreg[9:1]};
        end
      end else if (bit_cnt != 4'd0) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  // Prefix decoder; a completed key event is presented to the FIFO one cycle later
  dec_state_t state;
  logic       emit_vld;
  evt_t       emit;
  logic [7:0] byte_c;

  assign byte_c = shreg[8:1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      emit_vld <= 1'b0;
      emit     <= '0;
    end else begin
      emit_vld <= 1'b0;
      if (frame_bad_c) begin
        state <= IDLE;
      end else if (frame_ok_c) begin
        case (byte_c)
          8'hE0: state <= (state == BRK || state == EXT_BRK) ? EXT_BRK : EXT;
          8'hF0: state <= (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
          default: begin
            emit_vld  <= 1'b1;
            emit.code <= byte_c;
            emit.ext  <= (state == EXT || state == EXT_BRK);
            emit.brk  <= (state == BRK || state == EXT_BRK);
            state     <= IDLE;
          end
        endcase
      end
    end
  end

  // Event FIFO with a registered head entry
  evt_t          mem [FIFO_DEPTH];
  evt_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt_c;
  logic          pop_c, full_c, wr_c;

  assign pop_c       = evt_valid & evt_ready;
  assign full_c      = (count == CW'(FIFO_DEPTH));
  assign wr_c        = emit_vld && (!full_c || pop_c);
  assign count_nxt_c = count + CW'(wr_c) - CW'(pop_c);

  always_ff @(posedge clock) begin
    if (wr_c) mem[wr_ptr] <= emit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      evt_valid <= 1'b0;
      head      <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c) rd_ptr <= rd_ptr + PW'(1);
      count     <= count_nxt_c;
      evt_valid <= (count_nxt_c != '0);
      if (pop_c) begin
        if (count >= CW'(2)) head <= mem[rd_ptr + PW'(1)];
        else if (wr_c)       head <= emit;
      end else if (count == '0 && wr_c) begin
        head <= emit;
      end
      // A fresh drop takes priority over a clear in the same cycle
      if (emit_vld && full_c && !pop_c) overflow <= 1'b1;
      else if (clr_ovf)                 overflow <= 1'b0;
    end
  end

  assign evt_code   = head.code;
  assign evt_ext    = head.ext;
  assign evt_break  = head.brk;
  assign fifo_count = count;

endmodule

// File: tb/tb_ps2_kbd_event_rx.sv
// Bench for ps2_kbd_event_rx: directed scenarios plus randomized scan-code streams
// compared against a prefix/queue reference model.
module tb_ps2_kbd_event_rx;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 200;
  localparam int unsigned HALF  = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       frame_err;
  logic       overflow;
  logic       clr_ovf = 1'b0;
  logic [3:0] fifo_count;

  ps2_kbd_event_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_break(evt_break), .frame_err(frame_err),
    .overflow(overflow), .clr_ovf(clr_ovf), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending events, prefix flags, expected error and overflow state
  logic [9:0] exp_q[$];
  bit         m_ext, m_brk, m_ovf;
  int         err_exp = 0;
  int         err_seen = 0;
  int         ready_mode = 1;   // 0 low, 1 high, 2 random

  task automatic model_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      err_exp++;
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
      else m_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Drives nbits bits of one frame; the full frame updates the model at the stop-bit fall
  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
    logic [10:0] fr;
    logic        par;
    par = ~(^b) ^ bad;
    fr  = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      if (i == 10) model_byte(b, bad);
      cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    if (nbits == 11) cyc(12);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    exp_q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0;
    cyc(1);
  endtask

  // Ready driver
  initial begin
    evt_ready = 1'b1;
    forever begin
      @(posedge clock);
      #2;
      case (ready_mode)
        0: evt_ready = 1'b0;
        1: evt_ready = 1'b1;
        default: evt_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: every accepted event must match the model's next event
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_err) err_seen++;
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) check("unexpected_evt", {22'd0, evt_ext, evt_break, evt_code}, 32'h3ff);
        else check("evt", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    cyc(4);
    check("rst_valid", evt_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", frame_err, 0);
    check("rst_code", {evt_ext, evt_break, evt_code}, 0);
    do_reset();

    // Plain make code
    send(8'h1C);
    check("t1_err", err_seen, err_exp);
    check("t1_drain", exp_q.size(), 0);

    // Break and extended-break prefixes
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h75); send(8'h1B);
    check("t3_drain", exp_q.size(), 0);
    check("t3_count", fifo_count, 0);

    // Parity error, then a good code
    send_frame(8'h1C, 1'b1, 11);
    check("t4_err", err_seen, err_exp);
    send(8'h1B);
    check("t4_drain", exp_q.size(), 0);

    // Overflow with consumer stalled
    ready_mode = 0;
    cyc(2);
    for (int i = 1; i <= 9; i++) send(8'(i));
    check("t5_count", fifo_count, DEPTH);
    check("t5_ovf", overflow, m_ovf);
    check("t5_head", {evt_valid, evt_code}, {1'b1, 8'h01});
    cyc(5);
    check("t5_hold", {evt_valid, evt_code}, {1'b1, 8'h01});
    ready_mode = 1;
    cyc(20);
    check("t5_drained", exp_q.size(), 0);
    check("t5_count0", fifo_count, 0);
    check("t5_ovf_kept", overflow, 1);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    m_ovf = 0;
    check("t5_ovf_clr", overflow, m_ovf);

    // Timeout mid-frame after a break prefix
    send(8'hF0);
    send_frame(8'h55, 1'b0, 5);
    err_exp++; m_ext = 0; m_brk = 0;
    cyc(TMO + 10);
    check("t6_tmo_err", err_seen, err_exp);
    send(8'h1C);
    check("t6_after_tmo", exp_q.size(), 0);

    // Reset mid-frame after an extended prefix
    send(8'hE0);
    send_frame(8'h55, 1'b0, 5);
    do_reset();
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_valid", evt_valid, 0);
    send(8'h1C);
    cyc(TMO + 10);
    check("t6_rst_err", err_seen, err_exp);
    check("t6_after_rst", exp_q.size(), 0);

    // Randomized streams with random backpressure
    ready_mode = 2;
    for (int i = 0; i < 60; i++) begin
      int unsigned r;
      logic [7:0]  b;
      r = $urandom_range(0, 99);
      b = 8'($urandom_range(0, 255));
      if (r < 25)      send(8'hE0);
      else if (r < 45) send(8'hF0);
      else if (r < 52) send_frame(b, 1'b1, 11);
      else if (b == 8'hE0 || b == 8'hF0) send(8'h2A);
      else send(b);
      check("rnd_count", fifo_count, exp_q.size());
    end
    ready_mode = 1;
    cyc(30);
    check("rnd_drain", exp_q.size(), 0);
    check("rnd_err", err_seen, err_exp);
    check("rnd_ovf", overflow, m_ovf);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time guard
  initial begin
    #5ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
